fpu_sched: RTL and testbench

Two-requester scheduler and sequencer for the shared combinational `fpu` datapath. Arbitrates round-robin between two requesters, registers the winner's operands and operation into the `fpu` inputs, allows a fixed settle time, then captures the 32-bit IEEE-754 result and returns it with a one-cycle done pulse. It sits between the CPU-side FPU command paths and the single `fpu` instance it owns.

---
 rtl/fpu_sched_pkg.sv | 58 +++++
 rtl/fpu_sched_fpu.sv | 71 +++++++
 rtl/fpu_sched.sv | 105 ++++++++++
 tb/tb_fpu_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared FPU types and constants, plus the normalise/round/pack helpers used by the fpu datapath.
package pa_fpu;

   typedef enum logic [1:0] {op_add, op_sub, op_mul, op_div} e_fpu_op;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} e_fpu_sched_state;

   localparam int          NBR_FPU_REQ = 2;
   localparam logic [31:0] FPU_QNAN    = 32'h7fc00000;

   function automatic logic [5:0] lzc48(input logic [47:0] v);
      logic [5:0] n;
      n = 6'd48;
      for (int unsigned i = 0; i < 48; i++)
         if (v[i]) n = 6'(47 - i);
      return n;
   endfunction

   // Right shift that ORs every bit shifted out into the LSB (sticky).
   function automatic logic [47:0] shr_jam(input logic [47:0] v, input logic [10:0] n);
      logic [47:0] r;
      logic        s;
      if (n >= 11'd48) begin
         r = '0;
         s = |v;
      end else begin
         r = v >> n;
         s = |(v & ~({48{1'b1}} << n));
      end
      return {r[47:1], r[0] | s};
   endfunction

   // Value is m_in/2^47 * 2^(e_in-127); round to nearest even, handle subnormals and overflow.
   function automatic logic [31:0] round_pack(input logic s, input logic signed [10:0] e_in,
                                              input logic [47:0] m_in);
      logic [47:0]        m;
      logic signed [10:0] e;
      logic [5:0]         lz;
      logic               rnd;
      logic [24:0]        sig;
      logic [30:0]        mag;
      if (m_in == '0) return {s, 31'd0};
      lz = lzc48(m_in);
      m  = m_in << lz;
      e  = e_in - $signed({5'd0, lz});
      if (e < 11'sd1) begin
         m = shr_jam(m, $unsigned(11'sd1 - e));
         e = 11'sd0;
      end
      if (e > 11'sd254) return {s, 8'hff, 23'd0};
      rnd = m[23] & (m[24] | (|m[22:0]));
      sig = {1'b0, m[47:24]} + {24'd0, rnd};
      // Hidden bit in sig carries into the exponent field, so normal exponents are stored minus one.
      mag = {((e == 11'sd0) ? 8'd0 : (e[7:0] - 8'd1)), 23'd0} + {6'd0, sig};
      return {s, mag};
   endfunction

endpackage

// File: rtl/fpu_sched_fpu.sv
// Combinational IEEE-754 single-precision add/sub/mul datapath; division is unsupported and yields QNAN.
module fpu
   import pa_fpu::*;
(
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   input  e_fpu_op     operation,
   output logic [31:0] ieee_packet_out
);

   logic        a_sign, b_sign, bs;
   logic [7:0]  a_exp, b_exp, a_eff, b_eff;
   logic [23:0] a_man, b_man;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        swap, lg_sign, eff_sub, ms;
   logic [7:0]  lg_exp, sm_exp, diff;
   logic [23:0] lg_man, sm_man;
   logic [47:0] lg48, sm48, sum, prod;
   logic [31:0] add_res, mul_res;

   assign a_sign = a_operand[31];
   assign b_sign = b_operand[31];
   assign a_exp  = a_operand[30:23];
   assign b_exp  = b_operand[30:23];
   assign a_eff  = (a_exp == 8'd0) ? 8'd1 : a_exp;
   assign b_eff  = (b_exp == 8'd0) ? 8'd1 : b_exp;
   assign a_man  = {a_exp != 8'd0, a_operand[22:0]};
   assign b_man  = {b_exp != 8'd0, b_operand[22:0]};
   assign a_nan  = (a_exp == 8'hff) && (a_operand[22:0] != '0);
   assign b_nan  = (b_exp == 8'hff) && (b_operand[22:0] != '0);
   assign a_inf  = (a_exp == 8'hff) && (a_operand[22:0] == '0);
   assign b_inf  = (b_exp == 8'hff) && (b_operand[22:0] == '0);
   assign a_zero = (a_operand[30:0] == '0);
   assign b_zero = (b_operand[30:0] == '0);

   always_comb begin
      bs      = b_sign ^ (operation == op_sub);
      swap    = b_operand[30:0] > a_operand[30:0];
      lg_sign = swap ? bs    : a_sign;
      lg_exp  = swap ? b_eff : a_eff;
      sm_exp  = swap ? a_eff : b_eff;
      lg_man  = swap ? b_man : a_man;
      sm_man  = swap ? a_man : b_man;
      eff_sub = a_sign ^ bs;
      diff    = lg_exp - sm_exp;
      lg48    = {1'b0, lg_man, 23'd0};
      sm48    = shr_jam({1'b0, sm_man, 23'd0}, {3'd0, diff});
      sum     = eff_sub ? (lg48 - sm48) : (lg48 + sm48);
      // Exact cancellation rounds to +0.
      add_res = round_pack((eff_sub && (sum == '0)) ? 1'b0 : lg_sign,
                           $signed({3'd0, lg_exp}) + 11'sd1, sum);
      if (a_nan || b_nan)      add_res = FPU_QNAN;
      else if (a_inf && b_inf) add_res = (a_sign != bs) ? FPU_QNAN : a_operand;
      else if (a_inf)          add_res = a_operand;
      else if (b_inf)          add_res = {bs, b_operand[30:0]};

      ms      = a_sign ^ b_sign;
      prod    = a_man * b_man;
      mul_res = round_pack(ms, $signed({3'd0, a_eff}) + $signed({3'd0, b_eff}) - 11'sd126, prod);
      if (a_nan || b_nan)                          mul_res = FPU_QNAN;
      else if ((a_inf && b_zero) || (b_inf && a_zero)) mul_res = FPU_QNAN;
      else if (a_inf || b_inf)                     mul_res = {ms, 8'hff, 23'd0};

      unique case (operation)
         op_add, op_sub: ieee_packet_out = add_res;
         op_mul:         ieee_packet_out = mul_res;
         default:        ieee_packet_out = FPU_QNAN;
      endcase
   end

endmodule

// File: rtl/fpu_sched.sv
// Round-robin two-requester scheduler that sequences operations through a single shared fpu.
module fpu_sched
   import pa_fpu::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NBR_FPU_REQ-1:0] req,
   input  logic [31:0]            a0_operand,
   input  logic [31:0]            b0_operand,
   input  logic [31:0]            a1_operand,
   input  logic [31:0]            b1_operand,
   input  e_fpu_op                op0,
   input  e_fpu_op                op1,
   output logic [NBR_FPU_REQ-1:0] ack,
   output logic [NBR_FPU_REQ-1:0] done,
   output logic [31:0]            result,
   output logic                   err,
   output logic                   busy
);

   e_fpu_sched_state state, next_state;
   logic [31:0]      a_reg, b_reg, fpu_out;
   e_fpu_op          op_reg;
   logic             winner, last_grant, pick;
   logic [3:0]       cnt;

   always_comb begin
      pick = 1'b0;
      unique case (req)
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_grant;
         default: pick = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (req != '0) next_state = EXEC;
         EXEC:    if (cnt == 4'd0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   fpu fpu_top (
      .a_operand      (a_reg),
      .b_operand      (b_reg),
      .operation      (op_reg),
      .ieee_packet_out(fpu_out)
   );

   // done/err are raised on the EXEC->DONE edge so they are visible while in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack        <= '0;
         done       <= '0;
         result     <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= op_add;
         winner     <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         ack  <= '0;
         done <= '0;
         err  <= 1'b0;
         busy <= (next_state != IDLE);
         unique case (state)
            IDLE: begin
               if (req != '0) begin
                  a_reg     <= pick ? a1_operand : a0_operand;
                  b_reg     <= pick ? b1_operand : b0_operand;
                  op_reg    <= pick ? op1 : op0;
                  winner    <= pick;
                  cnt       <= 4'(SETTLE_CYCLES - 1);
                  ack[pick] <= 1'b1;
               end
            end
            EXEC: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) begin
                  result       <= (op_reg == op_div) ? FPU_QNAN : fpu_out;
                  err          <= (op_reg == op_div);
                  done[winner] <= 1'b1;
               end
            end
            DONE:    last_grant <= winner;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_sched.sv
// Scoreboard bench for fpu_sched: expected completions queued at issue, checked when done pulses.
module tb_fpu_sched;
   import pa_fpu::*;

   typedef struct {
      logic [1:0]  mask;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic        clk, rst;
   logic [1:0]  req, ack, done;
   logic [31:0] a0, b0, a1, b1, result;
   e_fpu_op     op0, op1;
   logic        err, busy;

   exp_t sb[$];
   exp_t ent;
   int   checks = 0;
   int   errors = 0;

   fpu_sched #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a0_operand(a0), .b0_operand(b0), .a1_operand(a1), .b1_operand(b1),
      .op0(op0), .op1(op1),
      .ack(ack), .done(done), .result(result), .err(err), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (!rst && done !== 2'b00) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected done=%b result=%h err=%b with nothing expected", done, result, err);
         end else begin
            ent = sb.pop_front();
            if (done !== ent.mask || result !== ent.res || err !== ent.err) begin
               errors++;
               $display("FAIL sb_done got done=%b result=%h err=%b expected done=%b result=%h err=%b",
                        done, result, err, ent.mask, ent.res, ent.err);
            end
         end
      end
   end

   task automatic push_exp(input logic [1:0] m, input logic [31:0] r, input logic e);
      exp_t x;
      x.mask = m; x.res = r; x.err = e;
      sb.push_back(x);
   endtask

   task automatic wait_ack(output logic [1:0] seen, output int cyc);
      seen = 2'b00;
      cyc  = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ack !== 2'b00) begin
            seen = ack;
            cyc  = i;
            break;
         end
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #2;
         if (sb.size() == 0) break;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain outstanding=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input e_fpu_op op);
      if (r == 0) begin a0 = a; b0 = b; op0 = op; end
      else        begin a1 = a; b1 = b; op1 = op; end
   endtask

   task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input e_fpu_op op,
                         input logic [31:0] exp_res, input logic exp_err);
      logic [1:0] seen;
      logic [1:0] m;
      int         c;
      m = (r == 0) ? 2'b01 : 2'b10;
      set_req(r, a, b, op);
      push_exp(m, exp_res, exp_err);
      req = m;
      wait_ack(seen, c);
      req = 2'b00;
      checks++;
      if (seen !== m) begin
         errors++;
         $display("FAIL run_ack got=%b required=%b", seen, m);
      end
      wait_drain();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ack !== 2'b00)     begin errors++; $display("FAIL reset_ack got=%b required=00", ack); end
      checks++; if (done !== 2'b00)    begin errors++; $display("FAIL reset_done got=%b required=00", done); end
      checks++; if (result !== 32'h0)  begin errors++; $display("FAIL reset_result got=%h required=00000000", result); end
      checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b required=0", err); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_req(0, 32'h3f800000, 32'h3f800000, op_add);
      push_exp(2'b01, 32'h40000000, 1'b0);
      req = 2'b01;
      @(posedge clk);
      @(negedge clk);
      checks++; if (ack !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL single_t1 ack=%b busy=%b required ack=01 busy=1", ack, busy); end
      req = 2'b00;
      @(negedge clk);
      checks++; if (ack !== 2'b00 || done !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL single_t2 ack=%b done=%b busy=%b required 00 00 1", ack, done, busy); end
      @(negedge clk);
      checks++; if (done !== 2'b01 || result !== 32'h40000000 || err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_t3 done=%b result=%h err=%b busy=%b required 01 40000000 0 1", done, result, err, busy); end
      @(negedge clk);
      checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_t4 done=%b busy=%b required 00 0", done, busy); end
      wait_drain();
   endtask

   task automatic test_tie();
      logic [1:0] seen;
      int         c;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 32'h41800000, 32'h42000000, op_mul);
      set_req(1, 32'h3f800000, 32'h3f800000, op_sub);
      push_exp(2'b01, 32'h44000000, 1'b0);
      push_exp(2'b10, 32'h00000000, 1'b0);
      req = 2'b11;
      wait_ack(seen, c);
      checks++; if (seen !== 2'b01 || c != 1) begin errors++; $display("FAIL tie_first ack=%b cyc=%0d required 01 at 1", seen, c); end
      req = 2'b10;
      wait_ack(seen, c);
      checks++; if (seen !== 2'b10 || c != 3) begin errors++; $display("FAIL tie_second ack=%b cyc=%0d required 10 at 3", seen, c); end
      req = 2'b00;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      logic [1:0] seen;
      logic [1:0] want;
      int         c;
      set_req(0, 32'h3f800000, 32'h3f800000, op_add);
      set_req(1, 32'h40000000, 32'h40400000, op_mul);
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push_exp(2'b01, 32'h40000000, 1'b0);
         else            push_exp(2'b10, 32'h40c00000, 1'b0);
      end
      req = 2'b11;
      for (int k = 0; k < 6; k++) begin
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         wait_ack(seen, c);
         checks++;
         if (seen !== want) begin errors++; $display("FAIL b2b_grant op=%0d got=%b required=%b", k, seen, want); end
      end
      req = 2'b00;
      wait_drain();
   endtask

   task automatic test_div();
      run_op(1, 32'h3f800000, 32'h40000000, op_div, 32'h7fc00000, 1'b1);
      run_op(0, 32'h3f800000, 32'h40000000, op_add, 32'h40400000, 1'b0);
   endtask

   task automatic test_rst_exec();
      logic [1:0] seen;
      int         c;
      set_req(0, 32'h40000000, 32'h40400000, op_mul);
      req = 2'b01;
      wait_ack(seen, c);
      req = 2'b00;
      checks++; if (seen !== 2'b01) begin errors++; $display("FAIL rstx_ack got=%b required=01", seen); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (done !== 2'b00 || ack !== 2'b00 || busy !== 1'b0 || err !== 1'b0 || result !== 32'h0) begin
         errors++; $display("FAIL rstx_state done=%b ack=%b busy=%b err=%b result=%h required 00 00 0 0 00000000", done, ack, busy, err, result); end
      rst = 1'b0;
      run_op(0, 32'h40000000, 32'h40400000, op_mul, 32'h40c00000, 1'b0);
   endtask

   task automatic test_special();
      run_op(0, 32'hff800000, 32'hff800000, op_sub, 32'h7fc00000, 1'b0);
      run_op(0, 32'h00000001, 32'h3f800000, op_mul, 32'h00000001, 1'b0);
      run_op(1, 32'h7f800000, 32'h3f800000, op_add, 32'h7f800000, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req = 2'b00;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      op0 = op_add; op1 = op_add;
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_div();
      test_rst_exec();
      test_special();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
